ulpi_link_ctrl: RTL and testbench
=================================

// Module: ulpi_link_ctrl
// PURPOSE
//  ULPI link-side controller for the USB3300 sniffer: owns the 8-bit ULPI bus and arbitrates link TX (register
//  write/read) against PHY-driven RX (RX CMD bytes, packet data). Packet bytes are buffered in an RX FIFO,
//  tagged with end-of-packet, for the capture path. Sits between the PHY pins and the sniffer core / UART bridge.
// PARAMETERS
//  RX_FIFO_DEPTH  16   RX FIFO entries (power of 2, >=4); entry = {last, byte}
//  NXT_TIMEOUT    255  cycles in TX_CMD waiting for NXT before abort with reg_err (1..65535)
// PORTS
//  clk           in   1  ULPI 60 MHz clock (PHY CLKOUT)
//  rst           in   1  synchronous, active-high reset
//  reg_wr        in   1  start register write (sampled in IDLE only)
//  reg_rd        in   1  start register read (wr wins if both)
//  reg_addr      in   6  immediate register address
//  reg_wdata     in   8  write data
//  reg_rdata     out  8  read result, valid with reg_done after a read
//  reg_done      out  1  1-cycle pulse: register op finished (ok or error)
//  reg_err       out  1  1-cycle pulse with reg_done: NXT timeout
//  busy          out  1  high from accept until reg_done
//  rx_data       out  8  FIFO head byte
//  rx_last       out  1  FIFO head is last byte of packet
//  rx_valid      out  1  FIFO non-empty
//  rx_ready      in   1  pop head when rx_valid&rx_ready
//  rx_cmd        out  8  last RX CMD byte (LineState/VbusState/RxEvent)
//  rx_cmd_valid  out  1  1-cycle pulse on rx_cmd update
//  rx_overflow   out  1  sticky: byte dropped on full FIFO; cleared by rst only
//  ulpi_dir      in   1  PHY DIR
//  ulpi_nxt      in   1  PHY NXT
//  ulpi_data_i   in   8  bus input
//  ulpi_data_o   out  8  bus output
//  ulpi_data_oe  out  1  bus output enable (tristate at top level)
//  ulpi_stp      out  1  STP
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, rx_cmd=0. rst mid-op abandons op, no reg_done.
//  Turnaround: the cycle after any DIR edge; data_oe=0, bus ignored. data_oe = !dir & !turnaround; data_o=0x00 idle.
//  States: IDLE, TX_CMD, TX_DATA, TX_STP, RD_TURN, RD_DATA, RX.
//  IDLE: dir=1 -> RX. Else reg_wr -> TX_CMD with data_o={2'b10,addr}; reg_rd -> TX_CMD with {2'b11,addr}; busy=1.
//  TX_CMD: hold cmd until nxt=1; write -> TX_DATA (drive wdata); read -> RD_TURN (drive 0x00).
//    timeout counter hits NXT_TIMEOUT -> reg_done+reg_err, IDLE.
//  TX_DATA: hold wdata until nxt=1 -> TX_STP. TX_STP: stp=1, data_o=0x00 one cycle; reg_done next cycle; IDLE.
//  RD_TURN: wait dir=1 (turnaround cycle) -> RD_DATA; RD_DATA: latch data_i to reg_rdata, reg_done; wait dir=0.
//  Abort: dir rising in TX_CMD/TX_DATA aborts op; handle as RX; on return to IDLE the op reissues (no reg_done).
//  RX (dir=1, past turnaround): nxt=0 -> RX CMD: rx_cmd<=data_i, rx_cmd_valid pulse.
//    nxt=1 -> packet byte into 1-deep pending reg; previous pending pushed with last=0.
//    dir falls -> pending pushed with last=1. FIFO full at push -> byte dropped, rx_overflow=1.
//  FIFO: push and pop same cycle legal when full or empty (pop-first when full); latency push->rx_valid 1 cycle.
//  Pointers RX_FIFO_DEPTH-wrapping with extra MSB for full/empty.
// CONFIGURATION
//  ULPI_RXCMD_FILTER_EN defined: rx_cmd_valid pulses only if new RX CMD differs from stored rx_cmd.
//  Undefined: pulses on every RX CMD byte.
// TESTING
//  reg_wr addr 0x0A data 0x55, nxt after 2 cycles -> bus 0x8A,0x55, stp 1 cycle, reg_done, reg_err=0.
//  reg_rd addr 0x00, PHY nxt, dir=1, returns 0x24 -> reg_rdata=0x24 with reg_done, data_oe=0 while dir=1.
//  dir=1, RX CMD 0x4D then nxt bytes 0xC3,0x01,0x02, dir=0 -> rx_cmd=0x4D; FIFO pops C3/0,01/0,02/1.
//  rx_ready=0, 20 packet bytes, depth 16 -> 16 stored, rx_overflow=1, last stored byte last=0.
//  reg_wr, dir rises in TX_DATA -> no reg_done; after dir falls write reissued, completes once.
//  reg_rd, nxt never asserts -> after 255 cycles reg_done+reg_err, busy=0.

Source files
------------

// File: rtl/ulpi_link_ctrl.sv
// ULPI link-side controller: arbitrates register TX against PHY-driven RX and buffers packet bytes.
// Define ULPI_RXCMD_FILTER_EN to pulse rx_cmd_valid only when the RX CMD byte changes.
module ulpi_link_ctrl #(
   parameter int RX_FIFO_DEPTH = 16,
   parameter int NXT_TIMEOUT   = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       reg_wr,
   input  logic       reg_rd,
   input  logic [5:0] reg_addr,
   input  logic [7:0] reg_wdata,
   output logic [7:0] reg_rdata,
   output logic       reg_done,
   output logic       reg_err,
   output logic       busy,
   output logic [7:0] rx_data,
   output logic       rx_last,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [7:0] rx_cmd,
   output logic       rx_cmd_valid,
   output logic       rx_overflow,
   input  logic       ulpi_dir,
   input  logic       ulpi_nxt,
   input  logic [7:0] ulpi_data_i,
   output logic [7:0] ulpi_data_o,
   output logic       ulpi_data_oe,
   output logic       ulpi_stp
);

   localparam int AW = $clog2(RX_FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [15:0] TMO_LAST = 16'(NXT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, TX_CMD, TX_DATA, TX_STP, RD_TURN, RD_DATA, RX
   } state_t;

   state_t      state;
   logic        dir_q;
   logic        oe_en;
   logic        turnaround;
   logic        op_rd;
   logic [5:0]  op_addr;
   logic [7:0]  op_wdata;
   logic        reissue;
   logic        rd_got;
   logic [15:0] tmo_cnt;
   logic        pend_vld;
   logic [7:0]  pend_byte;

   logic        rx_live;
   logic        rx_end;
   logic        rxcmd_hit;
   logic        push;
   logic        push_last;
   logic        pop;
   logic        full;
   logic        empty;

   logic [8:0]  mem [RX_FIFO_DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic [8:0]  head;

   // The bus belongs to the PHY while dir is high and for the turnaround cycle after either edge.
   assign turnaround   = ulpi_dir ^ dir_q;
   assign ulpi_data_oe = oe_en & ~ulpi_dir & ~turnaround;

   assign rx_live   = (state == RX) & ulpi_dir & ~turnaround;
   assign rx_end    = (state == RX) & ~ulpi_dir;
   assign push      = pend_vld & ((rx_live & ulpi_nxt) | rx_end);
   assign push_last = rx_end;

`ifdef ULPI_RXCMD_FILTER_EN
   assign rxcmd_hit = rx_live & ~ulpi_nxt & (ulpi_data_i != rx_cmd);
`else
   assign rxcmd_hit = rx_live & ~ulpi_nxt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         dir_q        <= 1'b0;
         oe_en        <= 1'b0;
         op_rd        <= 1'b0;
         op_addr      <= 6'd0;
         op_wdata     <= 8'd0;
         reissue      <= 1'b0;
         rd_got       <= 1'b0;
         tmo_cnt      <= 16'd0;
         pend_vld     <= 1'b0;
         pend_byte    <= 8'd0;
         reg_rdata    <= 8'd0;
         reg_done     <= 1'b0;
         reg_err      <= 1'b0;
         busy         <= 1'b0;
         rx_cmd       <= 8'd0;
         rx_cmd_valid <= 1'b0;
         ulpi_data_o  <= 8'd0;
         ulpi_stp     <= 1'b0;
      end else begin
         dir_q        <= ulpi_dir;
         oe_en        <= 1'b1;
         reg_done     <= 1'b0;
         reg_err      <= 1'b0;
         rx_cmd_valid <= 1'b0;
         ulpi_stp     <= 1'b0;
         case (state)
            IDLE: begin
               ulpi_data_o <= 8'h00;
               if (ulpi_dir) begin
                  state <= RX;
               end else if (reissue || reg_wr || reg_rd) begin
                  if (!reissue) begin
                     op_rd    <= ~reg_wr;
                     op_addr  <= reg_addr;
                     op_wdata <= reg_wdata;
                  end
                  ulpi_data_o <= reissue ? {1'b1, op_rd, op_addr} : {1'b1, ~reg_wr, reg_addr};
                  busy        <= 1'b1;
                  reissue     <= 1'b0;
                  tmo_cnt     <= 16'd0;
                  state       <= TX_CMD;
               end
            end
            TX_CMD: begin
               if (ulpi_dir) begin
                  ulpi_data_o <= 8'h00;
                  reissue     <= 1'b1;
                  state       <= RX;
               end else if (ulpi_nxt) begin
                  ulpi_data_o <= op_rd ? 8'h00 : op_wdata;
                  state       <= op_rd ? RD_TURN : TX_DATA;
               end else if (tmo_cnt == TMO_LAST) begin
                  ulpi_data_o <= 8'h00;
                  reg_done    <= 1'b1;
                  reg_err     <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            TX_DATA: begin
               if (ulpi_dir) begin
                  ulpi_data_o <= 8'h00;
                  reissue     <= 1'b1;
                  state       <= RX;
               end else if (ulpi_nxt) begin
                  ulpi_data_o <= 8'h00;
                  ulpi_stp    <= 1'b1;
                  state       <= TX_STP;
               end
            end
            TX_STP: begin
               reg_done <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            RD_TURN: begin
               if (ulpi_dir) begin
                  rd_got <= 1'b0;
                  state  <= RD_DATA;
               end
            end
            RD_DATA: begin
               // First cycle after turnaround carries the register value; then wait out dir.
               if (!rd_got) begin
                  reg_rdata <= ulpi_data_i;
                  reg_done  <= 1'b1;
                  busy      <= 1'b0;
                  rd_got    <= 1'b1;
               end
               if (!ulpi_dir) state <= IDLE;
            end
            RX: begin
               if (!ulpi_dir) begin
                  pend_vld <= 1'b0;
                  state    <= IDLE;
               end else if (!turnaround) begin
                  if (ulpi_nxt) begin
                     pend_byte <= ulpi_data_i;
                     pend_vld  <= 1'b1;
                  end else begin
                     rx_cmd <= ulpi_data_i;
                     if (rxcmd_hit) rx_cmd_valid <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // RX FIFO: extra pointer MSB distinguishes full from empty.
   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rx_valid = ~empty;
   assign pop      = rx_valid & rx_ready;
   assign head     = mem[rptr[AW-1:0]];
   assign rx_data  = rx_valid ? head[7:0] : 8'h00;
   assign rx_last  = rx_valid & head[8];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr        <= '0;
         rptr        <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (pop) rptr <= rptr + PTR_ONE;
         if (push) begin
            if (!full || pop) wptr <= wptr + PTR_ONE;
            else              rx_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && (!full || pop)) mem[wptr[AW-1:0]] <= {push_last, pend_byte};
   end

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// Bench for ulpi_link_ctrl: PHY-side stimulus, randomized ops/packets, queue-based reference model.
module tb_ulpi_link_ctrl;

   localparam int DEPTH = 16;
   localparam int TMO   = 255;

   logic       clk = 1'b0;
   logic       rst;
   logic       reg_wr, reg_rd;
   logic [5:0] reg_addr;
   logic [7:0] reg_wdata, reg_rdata;
   logic       reg_done, reg_err, busy;
   logic [7:0] rx_data;
   logic       rx_last, rx_valid, rx_ready;
   logic [7:0] rx_cmd;
   logic       rx_cmd_valid, rx_overflow;
   logic       ulpi_dir, ulpi_nxt;
   logic [7:0] ulpi_data_i, ulpi_data_o;
   logic       ulpi_data_oe, ulpi_stp;

   always #5 clk = ~clk;

   ulpi_link_ctrl #(.RX_FIFO_DEPTH(DEPTH), .NXT_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_done(reg_done), .reg_err(reg_err), .busy(busy),
      .rx_data(rx_data), .rx_last(rx_last), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_cmd(rx_cmd), .rx_cmd_valid(rx_cmd_valid), .rx_overflow(rx_overflow),
      .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_i(ulpi_data_i),
      .ulpi_data_o(ulpi_data_o), .ulpi_data_oe(ulpi_data_oe), .ulpi_stp(ulpi_stp)
   );

   int checks = 0;
   int errors = 0;

   // Observations gathered by the PHY-side monitor
   logic [7:0] tx_q[$];
   logic [8:0] pop_q[$];
   int         stp_cnt = 0, done_cnt = 0, err_cnt = 0, bad_oe = 0, rxcmd_cnt = 0;
   logic [7:0] stp_byte = 8'h00, rd_cap = 8'h00;
   int         rdy_mode = 0;

   // Reference model state
   logic [8:0] items[$];
   logic [8:0] exp_q[$];
   logic [7:0] model_cmd = 8'h00;
   int         exp_cmd_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (ulpi_nxt && !ulpi_dir && ulpi_data_oe) tx_q.push_back(ulpi_data_o);
         if (ulpi_stp) begin stp_cnt++; stp_byte = ulpi_data_o; end
         if (reg_done) begin done_cnt++; rd_cap = reg_rdata; if (reg_err) err_cnt++; end
         if (ulpi_dir && ulpi_data_oe) bad_oe++;
         if (rx_cmd_valid) rxcmd_cnt++;
         if (rx_valid && rx_ready) pop_q.push_back({rx_last, rx_data});
      end
   end

   initial begin
      rx_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         rx_ready = (rdy_mode == 2) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic phy_nxt(input int d);
      ulpi_nxt = 1'b0;
      repeat (d) step();
      ulpi_nxt = 1'b1;
      step();
      ulpi_nxt = 1'b0;
   endtask

   function automatic void model_rxcmd(input logic [7:0] b);
`ifdef ULPI_RXCMD_FILTER_EN
      if (b != model_cmd) exp_cmd_cnt++;
`else
      exp_cmd_cnt++;
`endif
      model_cmd = b;
   endfunction

   task automatic wait_done(input string nm);
      int n = 0;
      while (!reg_done && n < 400) begin step(); n++; end
      if (!reg_done) begin
         checks++; errors++;
         $display("FAIL %s_done_timeout: no reg_done within %0d cycles", nm, n);
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst = 1'b1; reg_wr = 1'b1; reg_rd = 1'b0; reg_addr = 6'h3F; reg_wdata = 8'hFF;
      ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_i = 8'hA5;
      repeat (3) step();
      checks++;
      if ({busy, reg_done, reg_err, rx_valid, rx_cmd_valid, rx_overflow, ulpi_data_oe, ulpi_stp} !== 8'h00) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000000",
                  {busy, reg_done, reg_err, rx_valid, rx_cmd_valid, rx_overflow, ulpi_data_oe, ulpi_stp});
      end
      checks++;
      if ({reg_rdata, rx_cmd, ulpi_data_o, rx_data} !== 32'h0) begin
         errors++;
         $display("FAIL reset_bytes: got %h want 00000000", {reg_rdata, rx_cmd, ulpi_data_o, rx_data});
      end
      reg_wr = 1'b0; ulpi_data_i = 8'h00;
      rst = 1'b0;
      step();
      checks++;
      if (ulpi_data_oe !== 1'b1 || ulpi_data_o !== 8'h00) begin
         errors++;
         $display("FAIL idle_bus: oe=%b data=%h want oe=1 data=00", ulpi_data_oe, ulpi_data_o);
      end
   endtask

   task automatic test_write(input logic [5:0] a, input logic [7:0] d, input int d1, input int d2);
      int done0 = done_cnt, stp0 = stp_cnt, err0 = err_cnt;
      tx_q.delete();
      reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
      step();
      reg_wr = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
      phy_nxt(d1);
      phy_nxt(d2);
      wait_done("wr");
      checks++;
      if (tx_q.size() != 2 || tx_q[0] !== {2'b10, a} || tx_q[1] !== d) begin
         errors++;
         $display("FAIL wr_bus: got %0d bytes %p want %h,%h", tx_q.size(), tx_q, {2'b10, a}, d);
      end
      checks++;
      if (stp_cnt - stp0 != 1 || stp_byte !== 8'h00) begin
         errors++;
         $display("FAIL wr_stp: got %0d cycles data %h want 1 cycle data 00", stp_cnt - stp0, stp_byte);
      end
      checks++;
      if (done_cnt - done0 != 1 || err_cnt != err0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wr_done: got done=%0d err=%0d busy=%b want 1 0 0", done_cnt - done0, err_cnt - err0, busy);
      end
   endtask

   task automatic test_read(input logic [5:0] a, input logic [7:0] v, input int d1);
      int done0 = done_cnt, err0 = err_cnt, oe0 = bad_oe, c0 = rxcmd_cnt;
      tx_q.delete();
      reg_addr = a; reg_rd = 1'b1;
      step();
      reg_rd = 1'b0;
      phy_nxt(d1);
      ulpi_dir = 1'b1;
      step();
      ulpi_data_i = v;
      step();
      ulpi_dir = 1'b0; ulpi_data_i = 8'h00;
      repeat (4) step();
      checks++;
      if (tx_q.size() != 1 || tx_q[0] !== {2'b11, a}) begin
         errors++;
         $display("FAIL rd_cmd: got %0d bytes %p want %h", tx_q.size(), tx_q, {2'b11, a});
      end
      checks++;
      if (done_cnt - done0 != 1 || err_cnt != err0 || rd_cap !== v) begin
         errors++;
         $display("FAIL rd_data: got done=%0d err=%0d rdata=%h want 1 0 %h", done_cnt - done0, err_cnt - err0, rd_cap, v);
      end
      checks++;
      if (bad_oe != oe0 || rxcmd_cnt != c0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rd_bus: got oe_while_dir=%0d rxcmd=%0d busy=%b want 0 0 0", bad_oe - oe0, rxcmd_cnt - c0, busy);
      end
   endtask

   task automatic test_timeout(input logic [5:0] a);
      int n = 0;
      tx_q.delete();
      reg_addr = a; reg_rd = 1'b1;
      step();
      reg_rd = 1'b0;
      while (!reg_done && n < 1000) begin step(); n++; end
      checks++;
      if (n != TMO || reg_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout: got %0d cycles err=%b busy=%b want %0d 1 0", n, reg_err, busy, TMO);
      end
      repeat (3) step();
   endtask

   task automatic test_abort(input logic [5:0] a, input logic [7:0] d, input logic [7:0] c);
      int done0 = done_cnt, n = 0;
      tx_q.delete();
      reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
      step();
      reg_wr = 1'b0;
      phy_nxt($urandom_range(0, 3));
      ulpi_dir = 1'b1;
      step();
      ulpi_data_i = c;
      model_rxcmd(c);
      step();
      ulpi_dir = 1'b0; ulpi_data_i = 8'h00;
      step();
      while (!(ulpi_data_oe && ulpi_data_o[7]) && n < 50) begin step(); n++; end
      checks++;
      if (ulpi_data_oe !== 1'b1 || ulpi_data_o !== {2'b10, a} || done_cnt != done0) begin
         errors++;
         $display("FAIL abort_reissue: got oe=%b data=%h done=%0d want 1 %h 0", ulpi_data_oe, ulpi_data_o, done_cnt - done0, {2'b10, a});
      end
      phy_nxt($urandom_range(0, 3));
      phy_nxt($urandom_range(0, 3));
      wait_done("abort");
      checks++;
      if (tx_q.size() != 3 || tx_q[0] !== {2'b10, a} || tx_q[1] !== {2'b10, a} || tx_q[2] !== d) begin
         errors++;
         $display("FAIL abort_bus: got %p want %h,%h,%h", tx_q, {2'b10, a}, {2'b10, a}, d);
      end
      checks++;
      if (done_cnt - done0 != 1 || rx_cmd !== model_cmd || rxcmd_cnt != exp_cmd_cnt) begin
         errors++;
         $display("FAIL abort_done: got done=%0d rx_cmd=%h pulses=%0d want 1 %h %0d", done_cnt - done0, rx_cmd, rxcmd_cnt, model_cmd, exp_cmd_cnt);
      end
   endtask

   // Drives the items list as one dir-high burst and builds the expected FIFO contents
   task automatic run_rx(input int cap);
      logic [7:0] bytes[$];
      ulpi_dir = 1'b1; ulpi_nxt = 1'b0;
      step();
      foreach (items[i]) begin
         ulpi_nxt = items[i][8]; ulpi_data_i = items[i][7:0];
         if (items[i][8]) bytes.push_back(items[i][7:0]);
         else model_rxcmd(items[i][7:0]);
         step();
      end
      ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_i = 8'h00;
      step(); step();
      exp_q.delete();
      foreach (bytes[i])
         if (i < cap) exp_q.push_back({(i == bytes.size() - 1), bytes[i]});
   endtask

   task automatic drain_and_compare(input string nm);
      int n = 0;
      rdy_mode = 2;
      while (rx_valid && n < 100) begin step(); n++; end
      step();
      rdy_mode = 0;
      step();
      checks++;
      if (pop_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s_count: got %0d entries want %0d", nm, pop_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (pop_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL %s_entry%0d: got last=%b byte=%h want last=%b byte=%h", nm, i, pop_q[i][8], pop_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
            end
         end
      end
      checks++;
      if (rx_cmd !== model_cmd || rxcmd_cnt != exp_cmd_cnt) begin
         errors++;
         $display("FAIL %s_rxcmd: got %h pulses=%0d want %h %0d", nm, rx_cmd, rxcmd_cnt, model_cmd, exp_cmd_cnt);
      end
   endtask

   task automatic test_packets();
      for (int p = 0; p < 7; p++) begin
         items.delete(); pop_q.delete();
         if (p == 0) begin
            items = '{9'h04D, 9'h1C3, 9'h101, 9'h102};
         end else begin
            int nb = $urandom_range(1, 10);
            if ($urandom_range(0, 1) == 1) items.push_back({1'b0, 8'($urandom)});
            for (int k = 0; k < nb; k++) begin
               if ($urandom_range(0, 3) == 0) items.push_back({1'b0, 8'($urandom)});
               items.push_back({1'b1, 8'($urandom)});
            end
         end
         rdy_mode = 1;
         run_rx(DEPTH);
         drain_and_compare($sformatf("pkt%0d", p));
         checks++;
         if (rx_overflow !== 1'b0) begin errors++; $display("FAIL pkt%0d_ovf: got %b want 0", p, rx_overflow); end
      end
   endtask

   task automatic test_overflow();
      items.delete(); pop_q.delete();
      for (int k = 0; k < 20; k++) items.push_back({1'b1, 8'($urandom)});
      rdy_mode = 0;
      run_rx(DEPTH);
      checks++;
      if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", rx_overflow); end
      drain_and_compare("ovf");
      checks++;
      if (rx_overflow !== 1'b1 || rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_sticky: got ovf=%b valid=%b want 1 0", rx_overflow, rx_valid);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_cmd = 8'h00;
      step();
      checks++;
      if (rx_overflow !== 1'b0 || rx_cmd !== 8'h00) begin
         errors++;
         $display("FAIL ovf_clear: got ovf=%b rx_cmd=%h want 0 00", rx_overflow, rx_cmd);
      end
   endtask

   task automatic test_reset_midop();
      int done0 = done_cnt;
      reg_addr = 6'h05; reg_wdata = 8'h11; reg_wr = 1'b1;
      step();
      reg_wr = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (5) step();
      checks++;
      if (done_cnt != done0 || busy !== 1'b0 || ulpi_data_o !== 8'h00) begin
         errors++;
         $display("FAIL rst_midop: got done=%0d busy=%b data=%h want 0 0 00", done_cnt - done0, busy, ulpi_data_o);
      end
   endtask

   initial begin
      test_reset();
      test_write(6'h0A, 8'h55, 2, 0);
      for (int i = 0; i < 5; i++)
         test_write(6'($urandom), 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
      test_read(6'h00, 8'h24, 1);
      for (int i = 0; i < 3; i++)
         test_read(6'($urandom), 8'($urandom), $urandom_range(0, 4));
      test_timeout(6'h00);
      test_abort(6'h16, 8'h3C, 8'h4E);
      test_abort(6'($urandom), 8'($urandom), 8'($urandom));
      test_packets();
      test_overflow();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
